// File: rtl/reservation_station.sv
// Unified reservation station between dispatch and the FU array.
// Buffers up to DEPTH rows. An internal scoreboard tracks physical-register
// readiness, and entries wake up on writeback broadcasts. Each cycle, at most
// one ready entry issues per functional unit.
// Optional build macro RS_OLDEST_FIRST_EN: keep a DEPTH x DEPTH age matrix and
// issue the oldest ready candidate per FU. When it is undefined, the
// lowest-index candidate issues instead.

package rs_pkg;
  localparam int RS_PREG_W = 6;
  localparam int RS_FU_W   = 2;
  localparam int RS_ROB_W  = 5;

  typedef struct packed {
    logic [RS_ROB_W-1:0]  ROBNumber;
    logic [RS_FU_W-1:0]   fu;
    logic [7:0]           Opcode;
    logic [RS_PREG_W-1:0] PRegAddrDst;
    logic [RS_PREG_W-1:0] PRegAddrSrc0;
    logic                 Src0Ready;
    logic [RS_PREG_W-1:0] PRegAddrSrc1;
    logic                 Src1Ready;
  } rs_row_struct;
endpackage

module reservation_station
  import rs_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int NUM_FU    = 3,
  parameter int NUM_PREGS = 64,
  parameter int PREG_W    = RS_PREG_W
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_flush,
  input  logic [1:0]                      i_disp_valid,
  input  rs_row_struct [0:1]              i_rs_rows,
  output logic                            o_disp_ready,
  input  logic [1:0]                      i_wb_valid,
  input  logic [1:0][PREG_W-1:0]          i_wb_preg,
  input  logic [NUM_FU-1:0]               i_fu_ready,
  output logic [NUM_FU-1:0]               o_issue_valid,
  output rs_row_struct [0:NUM_FU-1]       o_issue_rows,
  output logic [$clog2(DEPTH+1)-1:0]      o_free_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]     ent_valid;
  rs_row_struct         ent_row [DEPTH];
  logic [NUM_PREGS-1:0] sb;
  logic [NUM_PREGS-1:0] sb_next;

  logic [1:0]           accept;
  logic [IDX_W-1:0]     free_idx0, free_idx1;
  logic                 have0, have1;
  logic [IDX_W-1:0]     ins_idx [2];
  logic [DEPTH-1:0]     ins_mask;
  rs_row_struct         new_row [2];

  logic [DEPTH-1:0]     cand [NUM_FU];
  logic [NUM_FU-1:0]    sel_valid;
  logic [IDX_W-1:0]     sel_idx [NUM_FU];
  logic [DEPTH-1:0]     issue_mask;
  logic [CNT_W-1:0]     ins_cnt, iss_cnt;

`ifdef RS_OLDEST_FIRST_EN
  // age[i][j] set means entry i arrived before entry j
  logic [DEPTH-1:0]     age [DEPTH];
`endif

  // True when any valid writeback port broadcasts this tag
  function automatic logic tag_hit(input logic [PREG_W-1:0] tag,
                                   input logic [1:0] wv,
                                   input logic [1:0][PREG_W-1:0] wp);
    return (wv[0] && (wp[0] == tag)) || (wv[1] && (wp[1] == tag));
  endfunction

  // Issued rows always leave with both sources marked ready
  function automatic rs_row_struct issued_row(input rs_row_struct r);
    rs_row_struct o;
    o = r;
    o.Src0Ready = 1'b1;
    o.Src1Ready = 1'b1;
    return o;
  endfunction

  assign o_disp_ready = (o_free_count >= CNT_W'(2));
  assign accept       = i_disp_valid & {2{o_disp_ready}};
  assign ins_cnt      = CNT_W'(accept[0]) + CNT_W'(accept[1]);

  // Find the two lowest-index free entries for this cycle's arrivals
  always_comb begin
    free_idx0 = '0;
    free_idx1 = '0;
    have0     = 1'b0;
    have1     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent_valid[i]) begin
        if (!have0) begin
          free_idx0 = IDX_W'(i);
          have0     = 1'b1;
        end else if (!have1) begin
          free_idx1 = IDX_W'(i);
          have1     = 1'b1;
        end
      end
    end
    ins_idx[0] = free_idx0;
    ins_idx[1] = accept[0] ? free_idx1 : free_idx0;
    ins_mask   = '0;
    for (int s = 0; s < 2; s++)
      if (accept[s]) ins_mask[ins_idx[s]] = 1'b1;
  end

  // Build arriving rows with source readiness resolved against scoreboard and bypass
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      new_row[s] = i_rs_rows[s];
      new_row[s].Src0Ready = (i_rs_rows[s].PRegAddrSrc0 == '0) || sb[i_rs_rows[s].PRegAddrSrc0] ||
                             tag_hit(i_rs_rows[s].PRegAddrSrc0, i_wb_valid, i_wb_preg);
      new_row[s].Src1Ready = (i_rs_rows[s].PRegAddrSrc1 == '0) || sb[i_rs_rows[s].PRegAddrSrc1] ||
                             tag_hit(i_rs_rows[s].PRegAddrSrc1, i_wb_valid, i_wb_preg);
    end
    // slot1 consuming slot0's result must wait for that result's writeback
    if (accept[0] && (i_rs_rows[0].PRegAddrDst != '0)) begin
      if (i_rs_rows[1].PRegAddrSrc0 == i_rs_rows[0].PRegAddrDst) new_row[1].Src0Ready = 1'b0;
      if (i_rs_rows[1].PRegAddrSrc1 == i_rs_rows[0].PRegAddrDst) new_row[1].Src1Ready = 1'b0;
    end
  end

  // Scoreboard next state: writeback sets, new destinations clear (clear wins), p0 pinned ready
  always_comb begin
    sb_next = sb;
    for (int k = 0; k < 2; k++)
      if (i_wb_valid[k]) sb_next[i_wb_preg[k]] = 1'b1;
    for (int s = 0; s < 2; s++)
      if (accept[s] && (i_rs_rows[s].PRegAddrDst != '0)) sb_next[i_rs_rows[s].PRegAddrDst] = 1'b0;
    sb_next[0] = 1'b1;
  end

  // Per-FU selection on registered entry state
  always_comb begin
    logic [DEPTH-1:0] older;
    older      = '0;
    issue_mask = '0;
    iss_cnt    = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      sel_valid[f] = 1'b0;
      sel_idx[f]   = '0;
      cand[f]      = '0;
      for (int i = 0; i < DEPTH; i++)
        cand[f][i] = ent_valid[i] && ent_row[i].Src0Ready && ent_row[i].Src1Ready &&
                     (int'(ent_row[i].fu) == f) && i_fu_ready[f];
`ifdef RS_OLDEST_FIRST_EN
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) older[j] = age[j][i];
        if (cand[f][i] && ((cand[f] & older) == '0)) begin
          sel_valid[f] = 1'b1;
          sel_idx[f]   = IDX_W'(i);
        end
      end
`else
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (cand[f][i]) begin
          sel_valid[f] = 1'b1;
          sel_idx[f]   = IDX_W'(i);
        end
      end
`endif
      if (sel_valid[f]) issue_mask[sel_idx[f]] = 1'b1;
      iss_cnt = iss_cnt + CNT_W'(sel_valid[f]);
    end
  end

  // Control state and registered issue outputs; reset and flush discard everything in flight
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      ent_valid     <= '0;
      sb            <= '1;
      o_issue_valid <= '0;
      o_free_count  <= CNT_W'(DEPTH);
      for (int f = 0; f < NUM_FU; f++) o_issue_rows[f] <= '0;
    end else begin
      ent_valid     <= (ent_valid & ~issue_mask) | ins_mask;
      sb            <= sb_next;
      o_issue_valid <= sel_valid;
      o_free_count  <= o_free_count - ins_cnt + iss_cnt;
      for (int f = 0; f < NUM_FU; f++)
        o_issue_rows[f] <= sel_valid[f] ? issued_row(ent_row[sel_idx[f]]) : '0;
    end
  end

  // Entry payload: wake sources on writeback, then write new arrivals
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (tag_hit(ent_row[i].PRegAddrSrc0, i_wb_valid, i_wb_preg)) ent_row[i].Src0Ready <= 1'b1;
      if (tag_hit(ent_row[i].PRegAddrSrc1, i_wb_valid, i_wb_preg)) ent_row[i].Src1Ready <= 1'b1;
    end
    for (int s = 0; s < 2; s++)
      if (accept[s]) ent_row[ins_idx[s]] <= new_row[s];
  end

`ifdef RS_OLDEST_FIRST_EN
  // New arrivals are younger than everything present; slot0 is older than slot1
  always_ff @(posedge i_clk) begin
    for (int s = 0; s < 2; s++) begin
      if (accept[s]) begin
        for (int j = 0; j < DEPTH; j++) age[j][ins_idx[s]] <= ent_valid[j];
        age[ins_idx[s]] <= '0;
      end
    end
    if (accept[0] && accept[1]) age[ins_idx[0]][ins_idx[1]] <= 1'b1;
  end
`endif

  // Dispatch protocol checks: no dispatch while not ready, no row for a nonexistent FU
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush) begin
      assert (!(|i_disp_valid) || o_disp_ready);
      for (int s = 0; s < 2; s++)
        if (accept[s]) assert (int'(i_rs_rows[s].fu) < NUM_FU);
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Testbench for reservation_station: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_reservation_station;
  import rs_pkg::*;

  localparam int DEPTH = 16;
  localparam int NUM_FU = 3;
  localparam int NUM_PREGS = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, flush, disp_ready;
  logic [1:0]            disp_valid, wb_valid;
  rs_row_struct [0:1]    rows;
  logic [1:0][5:0]       wb_preg;
  logic [2:0]            fu_ready, issue_valid;
  rs_row_struct [0:2]    issue_rows;
  logic [4:0]            free_count;

  reservation_station #(.DEPTH(DEPTH), .NUM_FU(NUM_FU), .NUM_PREGS(NUM_PREGS), .PREG_W(6)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_disp_valid(disp_valid), .i_rs_rows(rows),
    .o_disp_ready(disp_ready), .i_wb_valid(wb_valid), .i_wb_preg(wb_preg), .i_fu_ready(fu_ready),
    .o_issue_valid(issue_valid), .o_issue_rows(issue_rows), .o_free_count(free_count)
  );

  int n_checks = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit           v;
    rs_row_struct r;
    int unsigned  seq;
  } ment_t;

  ment_t        m_ent [DEPTH];
  bit           m_sb [NUM_PREGS];
  int           m_free;
  bit [2:0]     m_iv;
  rs_row_struct m_ir [3];
  int unsigned  m_seq = 0;

  function automatic bit on_wb(bit [5:0] tag);
    return (wb_valid[0] && wb_preg[0] == tag) || (wb_valid[1] && wb_preg[1] == tag);
  endfunction

  function automatic bit m_rdy(bit [5:0] tag);
    return (tag == 0) || m_sb[tag] || on_wb(tag);
  endfunction

  task automatic model_step();
    int pick, issued, n_ins;
    bit picked [DEPTH];
    bit [1:0] acc;
    rs_row_struct t;
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) m_ent[i].v = 0;
      for (int p = 0; p < NUM_PREGS; p++) m_sb[p] = 1;
      m_iv = 0;
      for (int f = 0; f < 3; f++) m_ir[f] = '0;
      m_free = DEPTH;
      return;
    end
    for (int i = 0; i < DEPTH; i++) picked[i] = 0;
    issued = 0;
    m_iv = 0;
    for (int f = 0; f < 3; f++) begin
      m_ir[f] = '0;
      pick = -1;
      if (fu_ready[f]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (m_ent[i].v && m_ent[i].r.Src0Ready && m_ent[i].r.Src1Ready && m_ent[i].r.fu == f) begin
`ifdef RS_OLDEST_FIRST_EN
            if (pick < 0 || m_ent[i].seq < m_ent[pick].seq) pick = i;
`else
            if (pick < 0) pick = i;
`endif
          end
        end
      end
      if (pick >= 0) begin
        t = m_ent[pick].r;
        t.Src0Ready = 1;
        t.Src1Ready = 1;
        m_iv[f] = 1;
        m_ir[f] = t;
        picked[pick] = 1;
        issued++;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m_ent[i].v && on_wb(m_ent[i].r.PRegAddrSrc0)) m_ent[i].r.Src0Ready = 1;
      if (m_ent[i].v && on_wb(m_ent[i].r.PRegAddrSrc1)) m_ent[i].r.Src1Ready = 1;
    end
    acc = (m_free >= 2) ? disp_valid : 2'b00;
    n_ins = 0;
    for (int s = 0; s < 2; s++) begin
      if (acc[s]) begin
        t = rows[s];
        t.Src0Ready = m_rdy(t.PRegAddrSrc0);
        t.Src1Ready = m_rdy(t.PRegAddrSrc1);
        if (s == 1 && acc[0] && rows[0].PRegAddrDst != 0) begin
          if (t.PRegAddrSrc0 == rows[0].PRegAddrDst) t.Src0Ready = 0;
          if (t.PRegAddrSrc1 == rows[0].PRegAddrDst) t.Src1Ready = 0;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (!m_ent[i].v) begin
            m_ent[i].v = 1;
            m_ent[i].r = t;
            m_ent[i].seq = m_seq;
            m_seq++;
            n_ins++;
            break;
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) if (wb_valid[k]) m_sb[wb_preg[k]] = 1;
    for (int s = 0; s < 2; s++) if (acc[s] && rows[s].PRegAddrDst != 0) m_sb[rows[s].PRegAddrDst] = 0;
    m_sb[0] = 1;
    for (int i = 0; i < DEPTH; i++) if (picked[i]) m_ent[i].v = 0;
    m_free = m_free - n_ins + issued;
  endtask

  // One clock: advance the model, clock the DUT, compare, clear one-shot inputs
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("model_issue_valid", 64'(issue_valid), 64'(m_iv));
    for (int f = 0; f < 3; f++)
      chk($sformatf("model_issue_row%0d", f), 64'(issue_rows[f]), 64'(m_ir[f]));
    chk("model_free_count", 64'(free_count), 64'(m_free));
    chk("model_disp_ready", 64'(disp_ready), 64'(m_free >= 2));
    disp_valid = 0;
    wb_valid = 0;
    flush = 0;
  endtask

  function automatic rs_row_struct mk(logic [4:0] rob, logic [1:0] fu, logic [5:0] dst,
                                      logic [5:0] s0, logic [5:0] s1);
    rs_row_struct r;
    r.ROBNumber = rob;
    r.fu = fu;
    r.Opcode = {3'b101, rob};
    r.PRegAddrDst = dst;
    r.PRegAddrSrc0 = s0;
    r.Src0Ready = 1'b1;
    r.PRegAddrSrc1 = s1;
    r.Src1Ready = 1'b1;
    return r;
  endfunction

  typedef struct {
    bit [1:0]     dv;
    rs_row_struct r0;
    rs_row_struct r1;
    bit [1:0]     wv;
    bit [5:0]     wp0;
    bit [2:0]     exp_iv;
    int           exp_free;
    bit [4:0]     rob0;
    bit [4:0]     rob1;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rob;
    rs_row_struct z;
    z = mk(0, 0, 0, 0, 0);
    tbl[0] = '{2'b11, mk(5, 0, 0, 0, 0), mk(6, 1, 0, 0, 0), 2'b00, 6'd0, 3'b000, 14, 5'd0, 5'd0};
    tbl[1] = '{2'b00, z, z, 2'b00, 6'd0, 3'b011, 16, 5'd5, 5'd6};
    tbl[2] = '{2'b00, z, z, 2'b00, 6'd0, 3'b000, 16, 5'd0, 5'd0};
    tbl[3] = '{2'b11, mk(7, 0, 9, 0, 0), mk(8, 1, 0, 9, 0), 2'b00, 6'd0, 3'b000, 14, 5'd0, 5'd0};
    tbl[4] = '{2'b00, z, z, 2'b00, 6'd0, 3'b001, 15, 5'd7, 5'd0};
    tbl[5] = '{2'b00, z, z, 2'b00, 6'd0, 3'b000, 15, 5'd0, 5'd0};
    tbl[6] = '{2'b00, z, z, 2'b01, 6'd9, 3'b000, 15, 5'd0, 5'd0};
    tbl[7] = '{2'b00, z, z, 2'b00, 6'd0, 3'b010, 16, 5'd0, 5'd8};
    tbl[8] = '{2'b00, z, z, 2'b00, 6'd0, 3'b000, 16, 5'd0, 5'd0};

    rst = 1; flush = 0; disp_valid = 0; wb_valid = 0; fu_ready = 3'b000;
    rows[0] = z; rows[1] = z; wb_preg[0] = 0; wb_preg[1] = 0;
    cycle();
    cycle();
    rst = 0;
    cycle();
    chk("reset_free_count", 64'(free_count), 64'd16);
    chk("reset_disp_ready", 64'(disp_ready), 64'd1);
    chk("reset_issue_valid", 64'(issue_valid), 64'd0);

    // directed vectors: dual dispatch and intra-group dependency
    fu_ready = 3'b111;
    for (int k = 0; k < 9; k++) begin
      disp_valid = tbl[k].dv;
      rows[0] = tbl[k].r0;
      rows[1] = tbl[k].r1;
      wb_valid = tbl[k].wv;
      wb_preg[0] = tbl[k].wp0;
      cycle();
      chk($sformatf("tbl%0d_issue_valid", k), 64'(issue_valid), 64'(tbl[k].exp_iv));
      chk($sformatf("tbl%0d_free_count", k), 64'(free_count), 64'(tbl[k].exp_free));
      if (tbl[k].exp_iv[0]) begin
        chk($sformatf("tbl%0d_rob0", k), 64'(issue_rows[0].ROBNumber), 64'(tbl[k].rob0));
        chk($sformatf("tbl%0d_rdy0", k), 64'({issue_rows[0].Src0Ready, issue_rows[0].Src1Ready}), 64'd3);
      end
      if (tbl[k].exp_iv[1]) begin
        chk($sformatf("tbl%0d_rob1", k), 64'(issue_rows[1].ROBNumber), 64'(tbl[k].rob1));
        chk($sformatf("tbl%0d_rdy1", k), 64'({issue_rows[1].Src0Ready, issue_rows[1].Src1Ready}), 64'd3);
      end
    end

    // p5/p6 cleared by producers, then woken at t and t+3: issue appears at t+5
    rows[0] = mk(1, 0, 5, 0, 0); rows[1] = mk(2, 1, 6, 0, 0); disp_valid = 2'b11;
    cycle(); cycle(); cycle();
    rows[0] = mk(10, 2, 0, 5, 6); disp_valid = 2'b01;
    cycle(); cycle(); cycle();
    wb_valid = 2'b01; wb_preg[0] = 6'd5;
    cycle();
    chk("wb_t_plus1", 64'(issue_valid[2]), 64'd0);
    cycle();
    chk("wb_t_plus2", 64'(issue_valid[2]), 64'd0);
    cycle();
    chk("wb_t_plus3", 64'(issue_valid[2]), 64'd0);
    wb_valid = 2'b10; wb_preg[1] = 6'd6;
    cycle();
    chk("wb_t_plus4", 64'(issue_valid[2]), 64'd0);
    cycle();
    chk("wb_t_plus5_valid", 64'(issue_valid), 64'b100);
    chk("wb_t_plus5_rob", 64'(issue_rows[2].ROBNumber), 64'd10);
    cycle();
    chk("wb_after_free", 64'(free_count), 64'd16);

    // fill with FUs stalled, then release fu0
    fu_ready = 3'b000;
    for (int p = 0; p < 7; p++) begin
      rows[0] = mk(5'(p), 0, 0, 0, 0); rows[1] = mk(5'(p + 16), 0, 0, 0, 0); disp_valid = 2'b11;
      cycle();
    end
    chk("fill14_free", 64'(free_count), 64'd2);
    chk("fill14_ready", 64'(disp_ready), 64'd1);
    rows[0] = mk(7, 0, 0, 0, 0); rows[1] = mk(23, 0, 0, 0, 0); disp_valid = 2'b11;
    cycle();
    chk("fill16_free", 64'(free_count), 64'd0);
    chk("fill16_ready", 64'(disp_ready), 64'd0);
    cycle();
    chk("stalled_issue", 64'(issue_valid), 64'd0);
    fu_ready = 3'b001;
    cycle();
    chk("release1_free", 64'(free_count), 64'd1);
    chk("release1_ready", 64'(disp_ready), 64'd0);
    cycle();
    chk("release2_ready", 64'(disp_ready), 64'd1);
    for (int k = 0; k < 40 && free_count != 16; k++) cycle();
    chk("drain_free", 64'(free_count), 64'd16);

    // entry 3 older than entry 1, both ready on fu0; then flush
    fu_ready = 3'b000;
    rows[0] = mk(1, 2, 0, 0, 0); rows[1] = mk(2, 1, 0, 0, 0); disp_valid = 2'b11;
    cycle();
    rows[0] = mk(3, 2, 0, 0, 0); rows[1] = mk(21, 0, 0, 0, 0); disp_valid = 2'b11;
    cycle();
    fu_ready = 3'b010;
    cycle();
    chk("age_free_e1", 64'(issue_rows[1].ROBNumber), 64'd2);
    fu_ready = 3'b000;
    rows[0] = mk(11, 0, 0, 0, 0); disp_valid = 2'b01;
    cycle();
    fu_ready = 3'b001;
    cycle();
`ifdef RS_OLDEST_FIRST_EN
    exp_rob = 21;
`else
    exp_rob = 11;
`endif
    chk("age_issue_valid", 64'(issue_valid), 64'b001);
    chk("age_issue_rob", 64'(issue_rows[0].ROBNumber), 64'(exp_rob));
    flush = 1;
    cycle();
    chk("flush_issue_valid", 64'(issue_valid), 64'd0);
    chk("flush_free", 64'(free_count), 64'd16);

    // randomized traffic against the model, with occasional flush and one reset
    for (int c = 0; c < 800; c++) begin
      rst = (c == 400);
      fu_ready = 3'($urandom_range(0, 7));
      wb_valid = 2'($urandom_range(0, 3));
      wb_preg[0] = 6'($urandom_range(0, 7));
      wb_preg[1] = 6'($urandom_range(0, 7));
      for (int s = 0; s < 2; s++) begin
        rows[s] = mk(5'($urandom_range(0, 31)), 2'($urandom_range(0, 2)), 6'($urandom_range(0, 7)),
                     6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
        rows[s].Src0Ready = 1'($urandom_range(0, 1));
        rows[s].Src1Ready = 1'($urandom_range(0, 1));
      end
      disp_valid = (m_free >= 2) ? 2'($urandom_range(0, 3)) : 2'b00;
      flush = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
